key4_onehot: RTL and testbench

KEY4_ONEHOT -- requirements
Module: key4_onehot

---
 rtl/key4_onehot.sv | 129 ++++++++++++
 tb/tb_key4_onehot.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key4_onehot.sv
// Four-key push-button front end: synchronize, debounce, then capture a single key as a
// one-hot code held until acknowledged. Simultaneous multi-key presses flag multi_err instead.
module key4_onehot #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       ack,
  output logic [3:0] onehot,
  output logic       valid,
  output logic       multi_err
);

  typedef enum logic [1:0] {StIdle, StHold, StWaitRel} state_e;

  localparam logic [7:0] CntMax = 8'(DEB_CYCLES - 1);

  logic [3:0] s1_q, s2_q;
  logic [3:0] cand_q, cand_d;
  logic [3:0] deb_q, deb_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] onehot_q, onehot_d;
  logic       valid_q, valid_d;
  logic       multi_err_q, multi_err_d;
  state_e     state_q, state_d;

  logic one_key, multi_key;

  // Debounce: a vector must sit unchanged in s2 for DEB_CYCLES samples; cnt saturates.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign one_key   = (deb_q != 4'b0000) && ((deb_q & (deb_q - 4'd1)) == 4'b0000);
  assign multi_key = (deb_q != 4'b0000) && !one_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      deb_q       <= '0;
      onehot_q    <= '0;
      valid_q     <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      s1_q        <= key_in;
      s2_q        <= s1_q;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      onehot_q    <= onehot_d;
      valid_q     <= valid_d;
      multi_err_q <= multi_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (one_key)        state_d = StHold;
        else if (multi_key) state_d = StWaitRel;
      end
      StHold: begin
        if (ack) state_d = StWaitRel;
      end
      StWaitRel: begin
        if (deb_q == 4'b0000) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // HOLD ignores deb entirely, so a release or second key cannot disturb the held code.
  always_comb begin
    onehot_d    = onehot_q;
    valid_d     = valid_q;
    multi_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        onehot_d = '0;
        valid_d  = 1'b0;
        if (one_key) begin
          onehot_d = deb_q;
          valid_d  = 1'b1;
        end else if (multi_key) begin
          multi_err_d = 1'b1;
        end
      end
      StHold: begin
        if (ack) begin
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      end
      StWaitRel: begin
        onehot_d = '0;
        valid_d  = 1'b0;
      end
      default: begin
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  assign onehot    = onehot_q;
  assign valid     = valid_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_key4_onehot.sv
// Scoreboard bench for key4_onehot: stimulus pushes expected captures/multi-key events,
// a negedge monitor pops and checks them, including edge-exact latency.
module tb_key4_onehot;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [3:0] key_in;
  logic [3:0] onehot;
  logic       valid;
  logic       multi_err;

  key4_onehot #(.DEB_CYCLES(Deb)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .ack       (ack),
    .onehot    (onehot),
    .valid     (valid),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_multi;
    logic [3:0]  oh;
    logic [1:0]  y;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0] held       = 4'b0000;
  bit         valid_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] enc(input logic [3:0] v);
    case (v)
      4'b0001: enc = 2'd0;
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'bxx;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      valid_prev = 1'b0;
      held       = 4'b0000;
    end else begin
      if (multi_err || (valid && !valid_prev)) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, valid, multi_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", {31'd0, multi_err}, {31'd0, e.is_multi});
          chk("latency", cyc, e.at);
          if (!e.is_multi) begin
            held = e.oh;
            chk("onehot_capture", {28'd0, onehot}, {28'd0, e.oh});
            chk("encoder_y", {30'd0, enc(onehot)}, {30'd0, e.y});
          end else begin
            chk("multi_no_valid", {31'd0, valid}, 32'd0);
          end
        end
      end
      chk("onehot_vs_valid", {28'd0, onehot}, {28'd0, valid ? held : 4'b0000});
      valid_prev = valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; expected response appears after edge cyc+Deb+4.
  task automatic press(input logic [3:0] k, input bit expect_ev, input bit multi,
                       input logic [1:0] y);
    exp_t e;
    key_in = k;
    if (expect_ev) begin
      e.is_multi = multi;
      e.oh       = k;
      e.y        = y;
      e.at       = cyc + Deb + 4;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!valid && b < 40) begin
      @(negedge clk);
      b++;
    end
    chk("valid_timeout", {31'd0, valid}, 32'd1);
  endtask

  task automatic do_ack();
    tick(3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_clears", {27'd0, valid, onehot}, 32'd0);
  endtask

  task automatic async_reset_check(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk(name, {26'd0, valid, multi_err, onehot}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    ack    = 1'b0;
    key_in = 4'b0000;
    tick(2);
    chk("reset_outputs", {26'd0, valid, multi_err, onehot}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single key 0100 held 20 cycles, ack 3 cycles after valid
    press(4'b0100, 1'b1, 1'b0, 2'd2);
    wait_valid();
    do_ack();
    tick(10);
    key_in = 4'b0000;
    tick(12);

    // Short glitch is dropped
    press(4'b0001, 1'b0, 1'b0, 2'd0);
    tick(3);
    key_in = 4'b0000;
    tick(12);
    chk("glitch_deb", {28'd0, dut.deb_q}, 32'd0);

    // Two keys at once -> one multi_err pulse, then a clean capture
    press(4'b1010, 1'b1, 1'b1, 2'd0);
    tick(10);
    key_in = 4'b0000;
    tick(12);
    press(4'b1000, 1'b1, 1'b0, 2'd3);
    wait_valid();
    do_ack();
    key_in = 4'b0000;
    tick(12);

    // Release before ack, second key during HOLD is not captured
    press(4'b0010, 1'b1, 1'b0, 2'd1);
    wait_valid();
    key_in = 4'b0000;
    tick(10);
    press(4'b0001, 1'b0, 1'b0, 2'd0);
    tick(12);
    chk("hold_keeps_code", {27'd0, valid, onehot}, {27'd0, 1'b1, 4'b0010});
    do_ack();
    tick(5);
    key_in = 4'b0000;
    tick(12);
    press(4'b0001, 1'b1, 1'b0, 2'd0);
    wait_valid();
    do_ack();
    key_in = 4'b0000;
    tick(12);

    // Reset mid-debounce, then again during HOLD, key held throughout
    press(4'b0100, 1'b0, 1'b0, 2'd0);
    tick(4);
    async_reset_check("async_rst_debounce");
    tick(2);
    rst = 1'b0;
    press(4'b0100, 1'b1, 1'b0, 2'd2);
    wait_valid();
    tick(2);
    async_reset_check("async_rst_hold");
    tick(2);
    rst = 1'b0;
    press(4'b0100, 1'b1, 1'b0, 2'd2);
    wait_valid();
    do_ack();
    key_in = 4'b0000;
    tick(12);

    // Sweep each single key
    for (int i = 0; i < 4; i++) begin
      press(4'(1 << i), 1'b1, 1'b0, 2'(i));
      wait_valid();
      do_ack();
      key_in = 4'b0000;
      tick(12);
    end

    tick(5);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
